// File: rtl/card_dealer.sv
// card_dealer: deals cards from one 52-card deck without repetition.
// A free-running 16-bit Galois LFSR picks a starting slot; a linear probe
// walks upward (wrapping at 51) to the first card not yet dealt.
//
// Handshake: draw_req is a request pulse that is taken only while busy=0.
// Once taken, busy stays high through the card_valid cycle, and further
// requests are dropped (no queueing). card_valid is a one-cycle pulse;
// card_symbol/card_number are meaningful on that pulse and hold the last
// dealt card afterwards. A shuffle or rst in the card_valid cycle suppresses
// the pulse, so the consumer never sees a card from a deck that was just
// restored.
module card_dealer #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned DECK_SIZE = 52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle,
  input  logic       draw_req,
  output logic       card_valid,
  output logic [1:0] card_symbol,
  output logic [3:0] card_number,
  output logic       busy,
  output logic       draw_err,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic [1:0] dbg_state
);

  // An all-zero seed would lock the LFSR, so it falls back to the default.
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [5:0]  DECK      = 6'(DECK_SIZE);
  localparam logic [5:0]  LAST      = DECK - 6'd1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PICK    = 2'd1,
    S_PROBE   = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t                 state_q;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [DECK_SIZE-1:0]   used_q;
  logic [5:0]             left_q;
  logic [5:0]             idx_q;
  logic [1:0]             sym_q;
  logic [3:0]             num_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   err_q;

  logic [5:0]             pick_idx;
  logic [5:0]             probe_next;
  logic [1:0]             sym_d;
  logic [3:0]             num_d;
  logic [5:0]             rem;

  // LFSR next value: shift right, fold the mask in when a one falls out.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  end

  // Start slot from the low six LFSR bits folded into 0..51, and the probe step.
  always_comb begin
    pick_idx   = (lfsr_q[5:0] >= DECK) ? (lfsr_q[5:0] - DECK) : lfsr_q[5:0];
    probe_next = (idx_q == LAST) ? 6'd0 : (idx_q + 6'd1);
  end

  // Split the slot into suit (idx / 13) and rank (idx % 13 + 1).
  always_comb begin
    sym_d = 2'd0;
    rem   = idx_q;
    if (idx_q >= 6'd39) begin
      sym_d = 2'd3;
      rem   = idx_q - 6'd39;
    end else if (idx_q >= 6'd26) begin
      sym_d = 2'd2;
      rem   = idx_q - 6'd26;
    end else if (idx_q >= 6'd13) begin
      sym_d = 2'd1;
      rem   = idx_q - 6'd13;
    end
    num_d = 4'(rem + 6'd1);
  end

  // LFSR runs every cycle outside reset; shuffle leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Dealer FSM with its deck bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      used_q  <= '0;
      left_q  <= DECK;
      idx_q   <= 6'd0;
      sym_q   <= 2'd0;
      num_q   <= 4'd1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (shuffle) begin
      // Restore the deck and drop any draw in flight; last card stays visible.
      state_q <= S_IDLE;
      used_q  <= '0;
      left_q  <= DECK;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (draw_req) begin
            if (left_q != 6'd0) begin
              state_q <= S_PICK;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_PICK: begin
          idx_q   <= pick_idx;
          state_q <= S_PROBE;
        end
        S_PROBE: begin
          // Terminates: a draw is only accepted while some slot is still free.
          if (used_q[idx_q]) begin
            idx_q <= probe_next;
          end else begin
            used_q[idx_q] <= 1'b1;
            left_q        <= left_q - 6'd1;
            sym_q         <= sym_d;
            num_q         <= num_d;
            valid_q       <= 1'b1;
            state_q       <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign card_valid  = valid_q & ~shuffle & ~rst;
  assign card_symbol = sym_q;
  assign card_number = num_q;
  assign busy        = busy_q;
  assign draw_err    = err_q;
  assign cards_left  = left_q;
  assign deck_empty  = (left_q == 6'd0);
  assign dbg_state   = state_q;

endmodule
